// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared types and constants for the UART receive controller.
//   rx_state_e       - frame sequencing states
//   PRESCALE_DEFAULT - oversampling ratio used when an illegal Prescale is latched
//   EDGE_CNT_W       - width of the per-bit oversampling tick counter
//   prescale_legal() - 1 when the ratio is one of 4, 8, 16, 32
package uart_rx_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } rx_state_e;

  localparam int unsigned PRESCALE_DEFAULT = 8;
  localparam int unsigned EDGE_CNT_W       = 5;

  function automatic logic prescale_legal(input logic [5:0] prescale);
    return (prescale == 6'd4) || (prescale == 6'd8) || (prescale == 6'd16) ||
           (prescale == 6'd32);
  endfunction

endpackage

// File: rtl/uart_rx_edge_bit_counter.sv
// uart_rx_edge_bit_counter: oversampling tick counter plus bit counter.
// Ports:
//   i_clk, i_rst   - clock, asynchronous active-high reset
//   i_en           - count enable; both counters held at 0 while low
//   i_bit_clr      - restart the bit counter (frame/field boundary)
//   i_prescale     - latched oversampling ratio
//   o_edge_cnt     - tick within the current bit, 0..prescale-1
//   o_bit_cnt      - bits completed since the last i_bit_clr
//   o_wrap         - high on the last tick of a bit (the decision point)
import uart_rx_pkg::*;

module uart_rx_edge_bit_counter #(
  parameter int unsigned BitCntW = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_en,
  input  logic                  i_bit_clr,
  input  logic [5:0]            i_prescale,
  output logic [EDGE_CNT_W-1:0] o_edge_cnt,
  output logic [BitCntW-1:0]    o_bit_cnt,
  output logic                  o_wrap
);

  logic [EDGE_CNT_W-1:0] r_edge_cnt;
  logic [BitCntW-1:0]    r_bit_cnt;
  logic [5:0]            w_last;

  // 6-bit compare so that a ratio of 32 gives a last tick of 31.
  assign w_last = i_prescale - 6'd1;
  assign o_wrap = i_en && ({1'b0, r_edge_cnt} == w_last);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_edge_cnt <= '0;
      r_bit_cnt  <= '0;
    end else if (!i_en) begin
      r_edge_cnt <= '0;
      r_bit_cnt  <= '0;
    end else begin
      if (o_wrap) begin
        r_edge_cnt <= '0;
      end else begin
        r_edge_cnt <= r_edge_cnt + EDGE_CNT_W'(1);
      end
      if (i_bit_clr) begin
        r_bit_cnt <= '0;
      end else if (o_wrap) begin
        r_bit_cnt <= r_bit_cnt + BitCntW'(1);
      end
    end
  end

  assign o_edge_cnt = r_edge_cnt;
  assign o_bit_cnt  = r_bit_cnt;

endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: UART receive frame sequencer. Detects the start edge, steps through start,
// data, optional parity and stop bits at the oversampling decision point, and assembles
// the parallel word from the sampler's majority-voted bit.
// Build option: UART_RX_PARITY_EN enables the parity field, PAR_EN/PAR_TYP and par_err.
// Ports:
//   CLK, RST      - oversampling clock, asynchronous active-high reset
//   RX_IN         - synchronised serial line, idle high
//   Prescale      - oversampling ratio (4, 8, 16, 32; anything else runs at 8)
//   PAR_EN        - frame carries a parity bit
//   PAR_TYP       - 0 even, 1 odd parity
//   sampled_bit   - majority-voted bit from the data sampler
//   data_samp_en  - sampler enable, high outside IDLE
//   edge_cnt      - oversampling tick within the current bit
//   P_DATA        - last good data word
//   data_valid    - one-cycle pulse, P_DATA updated with a good frame
//   par_err       - one-cycle pulse, parity mismatch
//   stp_err       - one-cycle pulse, stop bit sampled low
import uart_rx_pkg::*;

module uart_rx_ctrl #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [5:0]            Prescale,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  sampled_bit,
  output logic                  data_samp_en,
  output logic [EDGE_CNT_W-1:0] edge_cnt,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err
);

  localparam int unsigned BitCntW = $clog2(DATA_WIDTH + 3);

  rx_state_e             r_state, w_state_d;
  logic [5:0]            r_prescale;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [DATA_WIDTH-1:0] r_p_data;
  logic                  r_samp_en;
  logic                  r_data_valid;
  logic                  r_stp_err;
  logic [EDGE_CNT_W-1:0] w_edge_cnt;
  logic [BitCntW-1:0]    w_bit_cnt;
  logic                  w_wrap;
  logic                  w_cnt_en;
  logic                  w_latch;
  logic                  w_bit_clr;
  logic                  w_result;
  logic                  w_last_bit;
  logic                  w_par_bad;

  assign w_cnt_en   = (r_state != StIdle);
  assign w_last_bit = (w_bit_cnt == BitCntW'(DATA_WIDTH - 1));

  uart_rx_edge_bit_counter #(
    .BitCntW (BitCntW)
  ) u_counter (
    .i_clk      (CLK),
    .i_rst      (RST),
    .i_en       (w_cnt_en),
    .i_bit_clr  (w_bit_clr),
    .i_prescale (r_prescale),
    .o_edge_cnt (w_edge_cnt),
    .o_bit_cnt  (w_bit_cnt),
    .o_wrap     (w_wrap)
  );

`ifdef UART_RX_PARITY_EN
  logic r_par_en;
  logic r_par_typ;
  logic r_par_flag;
  logic r_par_err;

  assign w_par_bad = r_par_flag;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_par_en   <= 1'b0;
      r_par_typ  <= 1'b0;
      r_par_flag <= 1'b0;
      r_par_err  <= 1'b0;
    end else begin
      r_par_err <= 1'b0;
      if (w_latch) begin
        r_par_en   <= PAR_EN;
        r_par_typ  <= PAR_TYP;
        r_par_flag <= 1'b0;
      end
      if (r_state == StParity && w_wrap) begin
        r_par_flag <= ((^r_shift) ^ r_par_typ) != sampled_bit;
      end
      if (w_result) begin
        r_par_err <= r_par_flag;
      end
    end
  end

  assign par_err = r_par_err;
`else
  logic w_unused_par;

  assign w_unused_par = PAR_EN ^ PAR_TYP;
  assign w_par_bad    = 1'b0;
  assign par_err      = 1'b0;
`endif

  always_comb begin
    w_state_d = r_state;
    w_latch   = 1'b0;
    w_bit_clr = 1'b0;
    w_result  = 1'b0;
    case (r_state)
      StIdle: begin
        if (!RX_IN) begin
          w_state_d = StStart;
          w_latch   = 1'b1;
        end
      end
      StStart: begin
        if (w_wrap) begin
          w_bit_clr = 1'b1;
          // A high start bit at the decision point was a line glitch.
          w_state_d = sampled_bit ? StIdle : StData;
        end
      end
      StData: begin
        if (w_wrap && w_last_bit) begin
`ifdef UART_RX_PARITY_EN
          w_state_d = r_par_en ? StParity : StStop;
`else
          w_state_d = StStop;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      StParity: begin
        if (w_wrap) begin
          w_state_d = StStop;
        end
      end
`endif
      StStop: begin
        if (w_wrap) begin
          w_result  = 1'b1;
          w_bit_clr = 1'b1;
          // A start bit directly after the stop bit is taken without an idle cycle.
          if (!RX_IN) begin
            w_state_d = StStart;
            w_latch   = 1'b1;
          end else begin
            w_state_d = StIdle;
          end
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state      <= StIdle;
      r_prescale   <= 6'(PRESCALE_DEFAULT);
      r_shift      <= '0;
      r_p_data     <= '0;
      r_samp_en    <= 1'b0;
      r_data_valid <= 1'b0;
      r_stp_err    <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_samp_en    <= (w_state_d != StIdle);
      r_data_valid <= 1'b0;
      r_stp_err    <= 1'b0;
      if (w_latch) begin
        r_prescale <= prescale_legal(Prescale) ? Prescale : 6'(PRESCALE_DEFAULT);
      end
      // LSB arrives first, so after DATA_WIDTH shifts it sits in bit 0.
      if (r_state == StData && w_wrap) begin
        r_shift <= {sampled_bit, r_shift[DATA_WIDTH-1:1]};
      end
      if (w_result) begin
        r_stp_err <= !sampled_bit;
        if (sampled_bit && !w_par_bad) begin
          r_data_valid <= 1'b1;
          r_p_data     <= r_shift;
        end
      end
    end
  end

  assign data_samp_en = r_samp_en;
  assign edge_cnt     = w_edge_cnt;
  assign P_DATA       = r_p_data;
  assign data_valid   = r_data_valid;
  assign stp_err      = r_stp_err;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: directed-vector bench for uart_rx_ctrl. The line driver plays the role of
// the RX pin and the data sampler: it drives each bit on RX_IN for Prescale cycles and
// presents the same value on sampled_bit from the middle of the bit onwards.
module tb_uart_rx_ctrl;

`ifdef UART_RX_PARITY_EN
  localparam bit ParOn = 1'b1;
`else
  localparam bit ParOn = 1'b0;
`endif

  logic       CLK;
  logic       RST;
  logic       RX_IN;
  logic [5:0] Prescale;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic       sampled_bit;
  logic       data_samp_en;
  logic [4:0] edge_cnt;
  logic [7:0] P_DATA;
  logic       data_valid;
  logic       par_err;
  logic       stp_err;

  uart_rx_ctrl #(
    .DATA_WIDTH (8)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .RX_IN        (RX_IN),
    .Prescale     (Prescale),
    .PAR_EN       (PAR_EN),
    .PAR_TYP      (PAR_TYP),
    .sampled_bit  (sampled_bit),
    .data_samp_en (data_samp_en),
    .edge_cnt     (edge_cnt),
    .P_DATA       (P_DATA),
    .data_valid   (data_valid),
    .par_err      (par_err),
    .stp_err      (stp_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Pulse monitor, sampled on the falling edge.
  int         dv_cnt = 0;
  int         par_cnt = 0;
  int         stp_cnt = 0;
  int         wide_cnt = 0;
  int         dv_cyc[16];
  logic [7:0] dv_dat[16];
  logic       prev_dv = 1'b0;
  logic       prev_pe = 1'b0;
  logic       prev_se = 1'b0;

  always @(negedge CLK) begin
    if (data_valid === 1'b1) begin
      if (dv_cnt < 16) begin
        dv_cyc[dv_cnt] <= cyc;
        dv_dat[dv_cnt] <= P_DATA;
      end
      dv_cnt <= dv_cnt + 1;
    end
    if (par_err === 1'b1) par_cnt <= par_cnt + 1;
    if (stp_err === 1'b1) stp_cnt <= stp_cnt + 1;
    if ((data_valid && prev_dv) || (par_err && prev_pe) || (stp_err && prev_se)) begin
      wide_cnt <= wide_cnt + 1;
    end
    prev_dv <= data_valid;
    prev_pe <= par_err;
    prev_se <= stp_err;
  end

  int n_vec = 0;
  int n_err = 0;
  int start_cyc = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send_bits(input int p, input logic [15:0] bits, input int n);
    for (int b = 0; b < n; b++) begin
      for (int c = 0; c < p; c++) begin
        tick();
        if (c == 0) begin
          RX_IN = bits[b];
          if (b == 0) start_cyc = cyc;
        end
        if (c == p / 2) sampled_bit = bits[b];
      end
    end
  endtask

  task automatic build_frame(input logic [7:0] d, input bit par_present, input logic par_bit,
                             input logic stop, output logic [15:0] bits, output int n);
    int idx;
    bits    = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i+1] = d[i];
    idx = 9;
    if (par_present) begin
      bits[idx] = par_bit;
      idx++;
    end
    bits[idx] = stop;
    n = idx + 1;
  endtask

  task automatic send_frame(input int p, input logic [7:0] d, input bit par_present,
                            input logic par_bit, input logic stop);
    logic [15:0] bits;
    int          n;
    build_frame(d, par_present, par_bit, stop, bits, n);
    send_bits(p, bits, n);
  endtask

  task automatic go_idle(input int n);
    for (int c = 0; c < n; c++) begin
      tick();
      RX_IN = 1'b1;
      if (c == 4) sampled_bit = 1'b1;
    end
  endtask

  int          b_dv, b_pe, b_se, s0;
  logic [7:0]  exp_pdata;
  logic [15:0] pbits;
  int          pn;

  initial begin
    RST = 1'b1; RX_IN = 1'b1; sampled_bit = 1'b1;
    Prescale = 6'd8; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    exp_pdata = 8'h00;
    repeat (3) tick();
    check("rst_samp_en", 32'(data_samp_en), 32'd0);
    check("rst_edge_cnt", 32'(edge_cnt), 32'd0);
    check("rst_p_data", 32'(P_DATA), 32'd0);
    check("rst_data_valid", 32'(data_valid), 32'd0);
    check("rst_par_err", 32'(par_err), 32'd0);
    check("rst_stp_err", 32'(stp_err), 32'd0);
    RST = 1'b0;
    go_idle(5);

    // Good frame 0xA5, even parity bit 0.
    b_dv = dv_cnt; b_pe = par_cnt; b_se = stp_cnt;
    Prescale = 6'd8; PAR_EN = 1'b1; PAR_TYP = 1'b0;
    send_frame(8, 8'hA5, ParOn, 1'b0, 1'b1);
    go_idle(20);
    check("t1_dv_count", 32'(dv_cnt - b_dv), 32'd1);
    check("t1_latency", 32'(dv_cyc[b_dv] - start_cyc), ParOn ? 32'd89 : 32'd81);
    check("t1_dv_data", 32'(dv_dat[b_dv]), 32'hA5);
    check("t1_par_err", 32'(par_cnt - b_pe), 32'd0);
    check("t1_stp_err", 32'(stp_cnt - b_se), 32'd0);
    exp_pdata = 8'hA5;
    check("t1_p_data", 32'(P_DATA), 32'(exp_pdata));

    // Start glitch: line low for two cycles only.
    b_dv = dv_cnt; b_pe = par_cnt; b_se = stp_cnt;
    PAR_EN = 1'b0;
    tick(); RX_IN = 1'b0; start_cyc = cyc;
    tick();
    tick(); RX_IN = 1'b1;
    repeat (4) tick();
    check("t2_edge_cnt_mid", 32'(edge_cnt), 32'd5);
    check("t2_samp_en_mid", 32'(data_samp_en), 32'd1);
    repeat (6) tick();
    check("t2_samp_en_idle", 32'(data_samp_en), 32'd0);
    check("t2_edge_cnt_idle", 32'(edge_cnt), 32'd0);
    go_idle(20);
    check("t2_no_pulses", 32'((dv_cnt - b_dv) + (par_cnt - b_pe) + (stp_cnt - b_se)), 32'd0);

    // Wrong odd parity on 0x3C (needs 1, sends 0).
    b_dv = dv_cnt; b_pe = par_cnt; b_se = stp_cnt;
    Prescale = 6'd16; PAR_EN = 1'b1; PAR_TYP = 1'b1;
    send_frame(16, 8'h3C, ParOn, 1'b0, 1'b1);
    go_idle(30);
    if (!ParOn) exp_pdata = 8'h3C;
    check("t3_par_err", 32'(par_cnt - b_pe), ParOn ? 32'd1 : 32'd0);
    check("t3_dv_count", 32'(dv_cnt - b_dv), ParOn ? 32'd0 : 32'd1);
    check("t3_stp_err", 32'(stp_cnt - b_se), 32'd0);
    check("t3_p_data", 32'(P_DATA), 32'(exp_pdata));

    // Stop bit low at Prescale 4.
    b_dv = dv_cnt; b_pe = par_cnt; b_se = stp_cnt;
    Prescale = 6'd4; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    send_frame(4, 8'h81, 1'b0, 1'b0, 1'b0);
    go_idle(20);
    check("t4_stp_err", 32'(stp_cnt - b_se), 32'd1);
    check("t4_dv_count", 32'(dv_cnt - b_dv), 32'd0);
    check("t4_par_err", 32'(par_cnt - b_pe), 32'd0);
    check("t4_p_data", 32'(P_DATA), 32'(exp_pdata));

    // Back-to-back frames at Prescale 32, no idle gap.
    b_dv = dv_cnt; b_pe = par_cnt; b_se = stp_cnt;
    Prescale = 6'd32;
    send_frame(32, 8'h00, 1'b0, 1'b0, 1'b1);
    s0 = start_cyc;
    send_frame(32, 8'hFF, 1'b0, 1'b0, 1'b1);
    go_idle(40);
    check("t5_dv_count", 32'(dv_cnt - b_dv), 32'd2);
    check("t5_latency", 32'(dv_cyc[b_dv] - s0), 32'd321);
    check("t5_gap", 32'(dv_cyc[b_dv+1] - dv_cyc[b_dv]), 32'd320);
    check("t5_data0", 32'(dv_dat[b_dv]), 32'h00);
    check("t5_data1", 32'(dv_dat[b_dv+1]), 32'hFF);
    check("t5_errors", 32'((par_cnt - b_pe) + (stp_cnt - b_se)), 32'd0);

    // Reset mid-frame, then a clean 0x55 with Prescale changed mid-frame.
    b_dv = dv_cnt; b_pe = par_cnt; b_se = stp_cnt;
    Prescale = 6'd8;
    build_frame(8'h12, 1'b0, 1'b0, 1'b1, pbits, pn);
    send_bits(8, pbits, 5);
    RST = 1'b1; RX_IN = 1'b1; sampled_bit = 1'b1;
    #1;
    check("t6_rst_samp_en", 32'(data_samp_en), 32'd0);
    check("t6_rst_p_data", 32'(P_DATA), 32'd0);
    tick();
    RST = 1'b0;
    go_idle(10);
    check("t6_no_pulses", 32'((dv_cnt - b_dv) + (par_cnt - b_pe) + (stp_cnt - b_se)), 32'd0);
    fork
      send_frame(8, 8'h55, 1'b0, 1'b0, 1'b1);
      begin
        repeat (30) tick();
        Prescale = 6'd16;
      end
    join
    go_idle(20);
    check("t6_dv_count", 32'(dv_cnt - b_dv), 32'd1);
    check("t6_latency", 32'(dv_cyc[b_dv] - start_cyc), 32'd81);
    check("t6_data", 32'(dv_dat[b_dv]), 32'h55);
    check("t6_p_data", 32'(P_DATA), 32'h55);
    check("t6_errors", 32'((par_cnt - b_pe) + (stp_cnt - b_se)), 32'd0);

    check("pulse_width", 32'(wide_cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
